led_status_arbiter: RTL

- Shares the board's single RGB status LED between N_REQ status sources, e.g. init-in-progress, idle, busy and error.
- Grants the LED to one source at a time under fixed priority, where index 0 is the highest.
- Enforces a minimum display (hold) time, then drives the granted colour with PWM dimming and an optional blink pattern.
- Sits between the system status flags and the top-level LED pins.

---
 rtl/led_pkg.sv | 36 +++
 rtl/led_pwm_gen.sv | 31 +++
 rtl/led_status_arbiter.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/led_pkg.sv
// Shared types and helpers for the status LED arbiter.
// Holds FSM states, RGB bit positions and the request priority encoder.
package led_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_OPEN = 2'd2
    } state_t;

    localparam int CLR_R = 2;
    localparam int CLR_G = 1;
    localparam int CLR_B = 0;

    localparam int PE_W = 32;

    typedef struct packed {
        logic       valid;
        logic [4:0] idx;
    } prio_t;

    // Lowest set bit wins, so bit 0 is the highest-priority source.
    function automatic prio_t lowestSet(input logic [PE_W-1:0] req);
        prio_t res;
        res.valid = 1'b0;
        res.idx   = '0;
        for (int i = PE_W - 1; i >= 0; i--) begin
            if (req[i]) begin
                res.valid = 1'b1;
                res.idx   = 5'(i);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/led_pwm_gen.sv
// Free-running PWM counter with a brightness compare.
// The counter is never restarted by grant changes, only by reset.
module led_pwm_gen #(
    parameter int PWM_PERIOD = 50,
    parameter int DUTY_W     = 6
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic [DUTY_W-1:0] i_duty,
    output logic              o_pwm_on
);

    localparam int CNT_W = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
    localparam int CMP_W = (CNT_W > DUTY_W) ? CNT_W : DUTY_W;

    logic [CNT_W-1:0] r_pwmCnt;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_pwmCnt <= '0;
        end else if (r_pwmCnt == CNT_W'(PWM_PERIOD - 1)) begin
            r_pwmCnt <= '0;
        end else begin
            r_pwmCnt <= r_pwmCnt + 1'b1;
        end
    end

    // Duty at or above the period keeps the output permanently on.
    assign o_pwm_on = CMP_W'(r_pwmCnt) < CMP_W'(i_duty);

endmodule

// File: rtl/led_status_arbiter.sv
// Fixed-priority owner selection for the single RGB status LED, with a
// minimum hold time, PWM dimming and optional blinking of the owner colour.
module led_status_arbiter #(
    parameter int N_REQ       = 4,
    parameter int PWM_PERIOD  = 50,
    parameter int DUTY_W      = 6,
    parameter int HOLD_TICKS  = 1000,
    parameter int BLINK_TICKS = 25000
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic [N_REQ-1:0]     i_req,
    input  logic [3*N_REQ-1:0]   i_color,
    input  logic [N_REQ-1:0]     i_blink,
    input  logic [DUTY_W-1:0]    i_duty,
    output logic [N_REQ-1:0]     o_grant,
    output logic                 o_busy,
    output logic                 o_led_r,
    output logic                 o_led_g,
    output logic                 o_led_b
);

    import led_pkg::*;

    localparam int HOLD_W  = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam int BLINK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    state_t              r_state;
    logic [N_REQ-1:0]    r_grant;
    logic                r_busy;
    logic [2:0]          r_color;
    logic                r_blink;
    logic                r_phase;
    logic [BLINK_W-1:0]  r_blinkCnt;
    logic [HOLD_W-1:0]   r_holdCnt;
    logic                r_ledR;
    logic                r_ledG;
    logic                r_ledB;

    prio_t               w_pe;
    logic [N_REQ-1:0]    w_newGrant;
    logic [2:0]          w_newColor;
    logic                w_newBlink;
    logic                w_takeGrant;
    logic                w_pwmOn;
    logic                w_lit;

    led_pwm_gen #(
        .PWM_PERIOD (PWM_PERIOD),
        .DUTY_W     (DUTY_W)
    ) u_pwm (
        .i_clock  (i_clock),
        .i_reset  (i_reset),
        .i_duty   (i_duty),
        .o_pwm_on (w_pwmOn)
    );

    // Winner of the current request vector together with its colour/blink.
    always_comb begin
        w_pe       = lowestSet(PE_W'(i_req));
        w_newGrant = '0;
        w_newColor = '0;
        w_newBlink = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (w_pe.valid && (w_pe.idx == 5'(k))) begin
                w_newGrant[k] = 1'b1;
                w_newColor    = i_color[3*k +: 3];
                w_newBlink    = i_blink[k];
            end
        end
        w_takeGrant = w_pe.valid &&
                      ((r_state == ST_IDLE) ||
                       ((r_state == ST_OPEN) && (w_newGrant != r_grant)));
        w_lit = w_pwmOn & (r_blink ? r_phase : 1'b1) & (r_state != ST_IDLE);
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_grant    <= '0;
            r_busy     <= 1'b0;
            r_color    <= '0;
            r_blink    <= 1'b0;
            r_phase    <= 1'b0;
            r_blinkCnt <= '0;
            r_holdCnt  <= '0;
            r_ledR     <= 1'b0;
            r_ledG     <= 1'b0;
            r_ledB     <= 1'b0;
        end else begin
            r_ledR <= r_color[CLR_R] & w_lit;
            r_ledG <= r_color[CLR_G] & w_lit;
            r_ledB <= r_color[CLR_B] & w_lit;

            if (r_blinkCnt == BLINK_W'(BLINK_TICKS - 1)) begin
                r_blinkCnt <= '0;
                r_phase    <= ~r_phase;
            end else begin
                r_blinkCnt <= r_blinkCnt + 1'b1;
            end

            // A fresh grant restarts the hold window and the blink pattern.
            if (w_takeGrant) begin
                r_state    <= ST_HOLD;
                r_grant    <= w_newGrant;
                r_busy     <= 1'b1;
                r_color    <= w_newColor;
                r_blink    <= w_newBlink;
                r_holdCnt  <= HOLD_W'(HOLD_TICKS - 1);
                r_blinkCnt <= '0;
                r_phase    <= 1'b1;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_grant <= '0;
                        r_busy  <= 1'b0;
                    end
                    ST_HOLD: begin
                        if (r_holdCnt == '0) begin
                            r_state <= ST_OPEN;
                        end else begin
                            r_holdCnt <= r_holdCnt - 1'b1;
                        end
                    end
                    ST_OPEN: begin
                        if (!w_pe.valid) begin
                            r_state <= ST_IDLE;
                            r_grant <= '0;
                            r_busy  <= 1'b0;
                        end else begin
                            r_color <= w_newColor;
                            r_blink <= w_newBlink;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_grant <= '0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_grant = r_grant;
    assign o_busy  = r_busy;
    assign o_led_r = r_ledR;
    assign o_led_g = r_ledG;
    assign o_led_b = r_ledB;

endmodule
